// File: rtl/mul_ctrl.sv
// RV32M multiply control: turns MUL/MULH/MULHSU/MULHU requests into unsigned operand
// magnitudes for a sequential multiplier, then sign-corrects the product and returns the
// selected word. Zero operands and repeats of the last product skip the multiplier.
module mul_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_CACHE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   result_o,
  output logic              result_valid_o,
  output logic              mul_start_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  input  logic [2*XLEN-1:0] mul_product_i,
  input  logic              mul_done_i
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  localparam logic [1:0] OpMul    = 2'b00;
  localparam logic [1:0] OpMulh   = 2'b01;
  localparam logic [1:0] OpMulhsu = 2'b10;

  // Signedness modes; MUL shares ss with MULH
  localparam logic [1:0] ModeSs = 2'd0;
  localparam logic [1:0] ModeSu = 2'd1;
  localparam logic [1:0] ModeUu = 2'd2;

  state_e              r_state;
  logic [XLEN-1:0]     r_result;
  logic                r_result_valid;
  logic                r_mul_start;
  logic [XLEN-1:0]     r_mul_a;
  logic [XLEN-1:0]     r_mul_b;
  logic                r_neg;
  logic [1:0]          r_op;
  logic [1:0]          r_mode;
  logic [XLEN-1:0]     r_rs1;
  logic [XLEN-1:0]     r_rs2;

  // One-entry product cache
  logic                r_c_valid;
  logic [XLEN-1:0]     r_c_rs1;
  logic [XLEN-1:0]     r_c_rs2;
  logic [1:0]          r_c_mode;
  logic [2*XLEN-1:0]   r_c_p;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [1:0]          w_mode;
  logic                w_zero;
  logic                w_hit;
  logic [XLEN-1:0]     w_hit_word;
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_prod_word;

  // Operand decode for the request currently on the inputs
  always_comb begin
    w_a_signed = (op_i == OpMul) || (op_i == OpMulh) || (op_i == OpMulhsu);
    w_b_signed = (op_i == OpMul) || (op_i == OpMulh);
    w_a_neg    = w_a_signed && rs1_i[XLEN-1];
    w_b_neg    = w_b_signed && rs2_i[XLEN-1];
    // Two's complement of the most negative value is itself, which is the right magnitude
    w_a_mag    = w_a_neg ? (~rs1_i + 1'b1) : rs1_i;
    w_b_mag    = w_b_neg ? (~rs2_i + 1'b1) : rs2_i;
    if (op_i == OpMulhsu) begin
      w_mode = ModeSu;
    end else if (w_b_signed) begin
      w_mode = ModeSs;
    end else begin
      w_mode = ModeUu;
    end
    w_zero = (rs1_i == '0) || (rs2_i == '0);
    // The low word is mode independent, so MUL can hit on any cached mode
    w_hit  = EN_CACHE && r_c_valid && (rs1_i == r_c_rs1) && (rs2_i == r_c_rs2) &&
             ((op_i == OpMul) || (w_mode == r_c_mode));
    w_hit_word = (op_i == OpMul) ? r_c_p[XLEN-1:0] : r_c_p[2*XLEN-1:XLEN];
  end

  // Sign correction of the multiplier result for the operation in flight
  always_comb begin
    w_prod_fix  = r_neg ? (~mul_product_i + 1'b1) : mul_product_i;
    w_prod_word = (r_op == OpMul) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
  end

  // Stall follows the request combinationally while idle so the pipeline holds it
  always_comb begin
    stall_o = ((r_state == StIdle) && valid_i) || (r_state == StStart) ||
              (r_state == StWait);
  end

  assign result_o       = r_result;
  assign result_valid_o = r_result_valid;
  assign mul_start_o    = r_mul_start;
  assign mul_a_o        = r_mul_a;
  assign mul_b_o        = r_mul_b;

  // Control FSM with registered outputs and cache update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= StIdle;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_mul_start    <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_neg          <= 1'b0;
      r_op           <= OpMul;
      r_mode         <= ModeSs;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_c_valid      <= 1'b0;
      r_c_rs1        <= '0;
      r_c_rs2        <= '0;
      r_c_mode       <= ModeSs;
      r_c_p          <= '0;
    end else begin
      r_result_valid <= 1'b0;
      r_mul_start    <= 1'b0;
      if (flush_i) begin
        // Leaving WAIT makes any late mul_done_i from the aborted op harmless
        r_state   <= StIdle;
        r_c_valid <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (valid_i) begin
              if (w_zero) begin
                r_result       <= '0;
                r_result_valid <= 1'b1;
                r_state        <= StDone;
              end else if (w_hit) begin
                r_result       <= w_hit_word;
                r_result_valid <= 1'b1;
                r_state        <= StDone;
              end else begin
                r_mul_a     <= w_a_mag;
                r_mul_b     <= w_b_mag;
                r_neg       <= w_a_neg ^ w_b_neg;
                r_op        <= op_i;
                r_mode      <= w_mode;
                r_rs1       <= rs1_i;
                r_rs2       <= rs2_i;
                r_mul_start <= 1'b1;
                r_state     <= StStart;
              end
            end
          end
          StStart: begin
            r_state <= StWait;
          end
          StWait: begin
            if (mul_done_i) begin
              r_result       <= w_prod_word;
              r_result_valid <= 1'b1;
              r_c_valid      <= 1'b1;
              r_c_rs1        <= r_rs1;
              r_c_rs2        <= r_rs2;
              r_c_mode       <= r_mode;
              r_c_p          <= w_prod_fix;
              r_state        <= StDone;
            end
          end
          StDone: begin
            r_state <= StIdle;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: plays the sequential multiplier, predicts every
// output per cycle from a high-level arithmetic model and a shadow product cache.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] result;
  logic        rv;
  logic        mstart;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [63:0] mprod = '0;
  logic        mdone = 1'b0;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations consumed by the monitor
  logic        mon_en = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_rv = 1'b0;
  logic [31:0] exp_res = '0;
  logic        exp_start = 1'b0;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;

  // Shadow of the one-entry cache
  bit          c_valid = 1'b0;
  logic [31:0] c_rs1 = '0;
  logic [31:0] c_rs2 = '0;
  int          c_mode = 0;

  mul_ctrl #(.XLEN(32), .EN_CACHE(1'b1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .valid_i        (valid),
    .op_i           (op),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .flush_i        (flush),
    .stall_o        (stall),
    .result_o       (result),
    .result_valid_o (rv),
    .mul_start_o    (mstart),
    .mul_a_o        (ma),
    .mul_b_o        (mb),
    .mul_product_i  (mprod),
    .mul_done_i     (mdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // True RV32M result from sign/zero-extended operands
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic        sa;
    logic        sb;
    logic [65:0] ea;
    logic [65:0] eb;
    logic [65:0] p;
    sa = (o != 2'b11);
    sb = (o == 2'b00) || (o == 2'b01);
    ea = {{34{sa & a[31]}}, a};
    eb = {{34{sb & b[31]}}, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mag(input bit is_signed, input logic [31:0] v);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic int mode_of(input logic [1:0] o);
    return (o == 2'b11) ? 2 : ((o == 2'b10) ? 1 : 0);
  endfunction

  // One compare process, every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("stall_o", {63'd0, stall}, {63'd0, exp_stall});
      chk("result_valid_o", {63'd0, rv}, {63'd0, exp_rv});
      if (exp_rv) chk("result_o", {32'd0, result}, {32'd0, exp_res});
      chk("mul_start_o", {63'd0, mstart}, {63'd0, exp_start});
      if (exp_start) begin
        chk("mul_a_o", {32'd0, ma}, {32'd0, exp_a});
        chk("mul_b_o", {32'd0, mb}, {32'd0, exp_b});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full request; lat = WAIT cycles before mul_done_i. use_lit pins the model to a literal.
  task automatic req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input bit use_lit, input logic [31:0] lit);
    logic [31:0] r;
    logic [31:0] xa;
    logic [31:0] xb;
    bit          hit;
    bit          zero;
    r    = ref_result(o, a, b);
    xa   = mag(o != 2'b11, a);
    xb   = mag((o == 2'b00) || (o == 2'b01), b);
    zero = (a == 0) || (b == 0);
    hit  = c_valid && (a == c_rs1) && (b == c_rs2) && ((o == 2'b00) || (mode_of(o) == c_mode));
    if (use_lit) chk("model_pin", {32'd0, r}, {32'd0, lit});
    valid = 1'b1; op = o; rs1 = a; rs2 = b;
    mprod = {$urandom, $urandom};
    exp_stall = 1'b1; exp_rv = 1'b0; exp_start = 1'b0;
    step();
    if (!zero && !hit) begin
      exp_start = 1'b1; exp_a = xa; exp_b = xb;
      step();
      exp_start = 1'b0;
      repeat (lat) step();
      mdone = 1'b1;
      mprod = {32'd0, xa} * {32'd0, xb};
      step();
      mdone = 1'b0;
      mprod = {$urandom, $urandom};
      c_valid = 1'b1; c_rs1 = a; c_rs2 = b; c_mode = mode_of(o);
    end
    // DONE cycle: request still held, must not be re-accepted
    exp_rv = 1'b1; exp_res = r; exp_stall = 1'b0;
    step();
    valid = 1'b0; exp_rv = 1'b0; exp_stall = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0; exp_stall = 1'b0; exp_rv = 1'b0; exp_start = 1'b0;
    repeat (n) step();
  endtask

  logic [31:0] pool [0:5];

  initial begin
    pool[0] = 32'h0000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
    pool[3] = 32'h0000_0003; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h1234_5678;

    // Reset state
    #12;
    chk("rst result_o", {32'd0, result}, 64'd0);
    chk("rst mul_a_o", {32'd0, ma}, 64'd0);
    chk("rst mul_b_o", {32'd0, mb}, 64'd0);
    chk("rst flags", {61'd0, stall, rv, mstart}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    idle(2);

    // Directed cases with literal expectations
    req(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1, 32'h0000_0000);
    req(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0001);
    idle(1);
    req(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1, 32'hFFFF_FFFF);
    req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b1, 32'hFFFF_FFFE);
    req(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 1'b1, 32'h4000_0000);
    req(2'b11, 32'h8000_0000, 32'h8000_0000, 1, 1'b1, 32'h4000_0000);
    req(2'b00, 32'h8000_0000, 32'h0000_0003, 2, 1'b1, 32'h8000_0000);
    req(2'b00, 32'h0000_0000, 32'h0000_1234, 0, 1'b1, 32'h0000_0000);
    idle(1);

    // Flush in WAIT, then a late mul_done_i must be ignored and the cache dropped
    req(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1'b0, 32'd0);
    valid = 1'b1; op = 2'b01; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
    exp_stall = 1'b1;
    step();
    exp_start = 1'b1; exp_a = 32'h1234_5678; exp_b = mag(1'b1, 32'h9ABC_DEF0);
    step();
    exp_start = 1'b0;
    step();
    flush = 1'b1; valid = 1'b0;
    step();
    flush = 1'b0; exp_stall = 1'b0;
    mdone = 1'b1; mprod = 64'h0123_4567_89AB_CDEF;
    step();
    mdone = 1'b0;
    c_valid = 1'b0;
    idle(3);
    // Would hit on the pre-flush entry if the cache survived
    req(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1'b0, 32'd0);
    idle(1);

    // Asynchronous reset in the middle of WAIT
    valid = 1'b1; op = 2'b11; rs1 = 32'hCAFE_0001; rs2 = 32'h0000_0100;
    exp_stall = 1'b1;
    step();
    exp_start = 1'b1; exp_a = 32'hCAFE_0001; exp_b = 32'h0000_0100;
    step();
    exp_start = 1'b0;
    step();
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0; valid = 1'b0;
    #1;
    chk("arst result_o", {32'd0, result}, 64'd0);
    chk("arst mul_a_o", {32'd0, ma}, 64'd0);
    chk("arst mul_b_o", {32'd0, mb}, 64'd0);
    chk("arst flags", {61'd0, stall, rv, mstart}, 64'd0);
    c_valid = 1'b0;
    exp_stall = 1'b0;
    step();
    #2;
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1, 32'hFFFF_FFFE);

    // Randomized traffic; small operand pool gives zeros, hits and sign corners
    for (int i = 0; i < 80; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 2'($urandom_range(0, 3));
      if (c_valid && ($urandom_range(0, 2) == 0)) begin
        a = c_rs1; b = c_rs2;
      end else begin
        a = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 5)];
        b = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 5)];
      end
      req(o, a, b, $urandom_range(0, 4), 1'b0, 32'd0);
      idle($urandom_range(0, 2));
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
